simon_iter_core: RTL and testbench

- Iterative, parametrised Simon block-cipher encryption core built around the Simon round function.
- Accepts one plaintext block and its master key via a valid/ready handshake.
- Runs all T rounds with on-the-fly key expansion, UNROLL rounds per clock, then presents the ciphertext on a valid/ready output port.
- Sits between the host interface and the result buffer; N, M and UNROLL select the Simon variant and the area/throughput point.

---
 rtl/simon_pkg.sv | 54 +++++
 rtl/simon_iter_core_round_step.sv | 43 ++++
 rtl/simon_iter_core.sv | 121 ++++++++++++
 tb/tb_simon_iter_core.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared constants for the Simon core: z sequences, per-variant round count and
// z-sequence selection, and the control FSM state type.
package simon_pkg;

  // Published sequences, leftmost digit (index 0) in the MSB.
  localparam logic [4:0][61:0] Z_TAB = '{
    62'b1101000111_1001101011_0110001000_0001011100_0011001010_0100111011_11, // z4
    62'b1101101110_1011000110_0101111000_0001001000_1010011100_1101000011_11, // z3
    62'b1010111101_1100000011_0100100110_0010100001_0001111110_0101101100_11, // z2
    62'b1000111011_1110010011_0000101101_0100011101_1111001001_1000010110_10, // z1
    62'b1111101000_1001010110_0001110011_0111110100_0100101011_0000111001_10  // z0
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Zero for an unsupported (N,M) pair.
  function automatic int simon_rounds(input int n, input int m);
    if (n == 16 && m == 4) return 32;
    if (n == 24 && m == 3) return 36;
    if (n == 24 && m == 4) return 36;
    if (n == 32 && m == 3) return 42;
    if (n == 32 && m == 4) return 44;
    if (n == 48 && m == 2) return 52;
    if (n == 48 && m == 3) return 54;
    if (n == 64 && m == 2) return 68;
    if (n == 64 && m == 3) return 69;
    if (n == 64 && m == 4) return 72;
    return 0;
  endfunction

  function automatic int simon_zsel(input int n, input int m);
    if (n == 16 && m == 4) return 0;
    if (n == 24 && m == 3) return 0;
    if (n == 24 && m == 4) return 1;
    if (n == 32 && m == 3) return 2;
    if (n == 32 && m == 4) return 3;
    if (n == 48 && m == 2) return 2;
    if (n == 48 && m == 3) return 3;
    if (n == 64 && m == 2) return 2;
    if (n == 64 && m == 3) return 3;
    if (n == 64 && m == 4) return 4;
    return 0;
  endfunction

  // Bit-reversed so that bit i of the result is sequence index i.
  function automatic logic [61:0] z_seq(input int sel);
    logic [61:0] s;
    logic [61:0] r;
    s = Z_TAB[sel];
    for (int i = 0; i < 62; i++) r[i] = s[61-i];
    return r;
  endfunction

endpackage

// File: rtl/simon_iter_core_round_step.sv
// One Simon round plus the matching key-schedule step, purely combinational.
module simon_round_step
  import simon_pkg::*;
#(
  parameter int N = 48,
  parameter int M = 2
) (
  input  logic [N-1:0]        x,
  input  logic [N-1:0]        y,
  input  logic [M-1:0][N-1:0] k,
  input  logic                z,
  output logic [N-1:0]        x_nx,
  output logic [N-1:0]        y_nx,
  output logic [M-1:0][N-1:0] k_nx
);

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  logic [N-1:0] t0, t1, t2, knew;

  always_comb begin
    t0   = ror(k[M-1], 3);
    t1   = (M == 4) ? (t0 ^ k[1]) : t0;
    t2   = t1 ^ ror(t1, 1);
    knew = ~k[0] ^ t2 ^ {{(N-1){1'b0}}, z} ^ N'(3);
  end

  assign x_nx = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[0];
  assign y_nx = x;

  // Consume word 0, shift down, append the freshly expanded word.
  for (genvar i = 0; i < M - 1; i++) begin : g_kshift
    assign k_nx[i] = k[i+1];
  end
  assign k_nx[M-1] = knew;

endmodule

// File: rtl/simon_iter_core.sv
// Iterative Simon encryption core: UNROLL rounds per clock with on-the-fly key
// expansion, valid/ready in and out.
module simon_iter_core
  import simon_pkg::*;
#(
  parameter int N      = 48,
  parameter int M      = 2,
  parameter int UNROLL = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] pt,
  input  logic [M*N-1:0] key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] ct,
  output logic           busy
);

  localparam int              T    = simon_rounds(N, M);
  localparam int              ZS   = simon_zsel(N, M);
  localparam int              RW   = (T > 1) ? $clog2(T) : 1;
  localparam logic [61:0]     ZSEQ = z_seq(ZS);

  if (T == 0) begin : g_bad_variant
    $error("simon_iter_core: (N,M) is not a Simon variant");
  end
  if (UNROLL < 1 || (T % UNROLL) != 0) begin : g_bad_unroll
    $error("simon_iter_core: UNROLL must divide the round count");
  end

  state_e                state_q, state_d;
  logic [RW-1:0]         r_q;
  logic [N-1:0]          x_q, y_q;
  logic [M-1:0][N-1:0]   k_q;
  logic [2*N-1:0]        ct_q;
  logic                  last;

  logic [UNROLL:0][N-1:0]        xc, yc;
  logic [UNROLL:0][M-1:0][N-1:0] kc;

  assign xc[0] = x_q;
  assign yc[0] = y_q;
  assign kc[0] = k_q;

  // Round r+u uses z index (r+u) mod 62; r+u < 124 so one subtract suffices.
  for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
    logic [6:0] zsum;
    logic [5:0] zidx;
    assign zsum = 7'(r_q) + 7'(u);
    assign zidx = (zsum >= 7'd62) ? 6'(zsum - 7'd62) : zsum[5:0];

    simon_round_step #(.N(N), .M(M)) u_step (
      .x    (xc[u]),
      .y    (yc[u]),
      .k    (kc[u]),
      .z    (ZSEQ[zidx]),
      .x_nx (xc[u+1]),
      .y_nx (yc[u+1]),
      .k_nx (kc[u+1])
    );
  end

  assign last = (int'(r_q) + UNROLL) == T;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          x_q <= pt[2*N-1:N];
          y_q <= pt[N-1:0];
          k_q <= key;
          r_q <= '0;
        end
        RUN: begin
          x_q <= xc[UNROLL];
          y_q <= yc[UNROLL];
          k_q <= kc[UNROLL];
          r_q <= r_q + RW'(UNROLL);
          if (last) ct_q <= {xc[UNROLL], yc[UNROLL]};
        end
        default: ;
      endcase
    end
  end

  assign ct = ct_q;

endmodule

// File: tb/tb_simon_iter_core.sv
// Directed bench for simon_iter_core across four variants with a ciphertext scoreboard.
module tb_simon_iter_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] pt_b;
  logic [255:0] key_b;
  logic [3:0]   iv, ordy, ir, ov, bz;
  logic [3:0][127:0] ct_a;
  logic [31:0]  ct16;
  logic [95:0]  ct48, ct48u;
  logic [127:0] ct64;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simon_iter_core #(.N(16), .M(4), .UNROLL(1)) d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .pt(pt_b[31:0]),
    .key(key_b[63:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .ct(ct16), .busy(bz[0]));
  simon_iter_core #(.N(48), .M(2), .UNROLL(1)) d48 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .pt(pt_b[95:0]),
    .key(key_b[95:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .ct(ct48), .busy(bz[1]));
  simon_iter_core #(.N(48), .M(2), .UNROLL(4)) d48u (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .pt(pt_b[95:0]),
    .key(key_b[95:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .ct(ct48u), .busy(bz[2]));
  simon_iter_core #(.N(64), .M(4), .UNROLL(1)) d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .pt(pt_b),
    .key(key_b), .out_valid(ov[3]), .out_ready(ordy[3]), .ct(ct64), .busy(bz[3]));

  assign ct_a[0] = {96'b0, ct16};
  assign ct_a[1] = {32'b0, ct48};
  assign ct_a[2] = {32'b0, ct48u};
  assign ct_a[3] = ct64;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a block in IDLE, push its expected ciphertext once accepted.
  task automatic send(input int d, input logic [127:0] p, input logic [255:0] k,
                      input logic [127:0] e);
    pt_b  = p;
    key_b = k;
    iv[d] = 1'b1;
    check("in_ready_idle", 128'(ir[d]), 128'(1));
    @(posedge clk); #1;
    iv[d]   = 1'b0;
    acc_cyc = cyc;
    exp_q.push_back(e);
    check("busy_run", 128'(bz[d]), 128'(1));
    check("in_ready_run", 128'(ir[d]), 128'(0));
  endtask

  // Wait (bounded) for out_valid, then check latency and pop/compare ct.
  task automatic wait_out(input int d, input int lat, input string tag);
    int n;
    logic [127:0] e;
    n = 0;
    while (!ov[d] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_out_valid"}, 128'(ov[d]), 128'(1));
    check({tag, "_latency"}, 128'(cyc - acc_cyc), 128'(lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check({tag, "_ct"}, ct_a[d], e);
  endtask

  task automatic release_out(input int d, input string tag);
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    check({tag, "_idle_ready"}, 128'(ir[d]), 128'(1));
    check({tag, "_valid_drop"}, 128'(ov[d]), 128'(0));
  endtask

  localparam logic [127:0] PT96  = {32'b0, 48'h2072616c6c69, 48'h702065687420};
  localparam logic [255:0] KEY96 = {160'b0, 48'h0d0c0b0a0908, 48'h050403020100};
  localparam logic [127:0] CT96  = {32'b0, 48'h602807a462b4, 48'h69063d8ff082};

  initial begin
    int seen;
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '0;
    pt_b  = '0;
    key_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int d = 0; d < 4; d++) begin
      check("rst_in_ready", 128'(ir[d]), 128'(1));
      check("rst_out_valid", 128'(ov[d]), 128'(0));
      check("rst_busy", 128'(bz[d]), 128'(0));
      check("rst_ct", ct_a[d], 128'(0));
    end

    // Simon32/64
    send(0, 128'h6565_6877, 256'h1918_1110_0908_0100, 128'hc69b_e9bb);
    wait_out(0, 32, "s32");
    release_out(0, "s32");

    // Simon96/96 with 20 cycles of backpressure
    send(1, PT96, KEY96, CT96);
    wait_out(1, 52, "s96");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_ct", ct_a[1], CT96);
      check("bp_valid", 128'(ov[1]), 128'(1));
      check("bp_in_ready", 128'(ir[1]), 128'(0));
    end
    release_out(1, "s96");

    // Simon96/96, four rounds per clock
    send(2, PT96, KEY96, CT96);
    wait_out(2, 13, "s96u4");
    release_out(2, "s96u4");

    // Reset in the middle of a block
    send(1, PT96, KEY96, CT96);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    check("mid_rst_valid", 128'(ov[1]), 128'(0));
    check("mid_rst_ct", ct_a[1], 128'(0));
    check("mid_rst_in_ready", 128'(ir[1]), 128'(1));
    check("mid_rst_busy", 128'(bz[1]), 128'(0));
    send(1, PT96, KEY96, CT96);
    wait_out(1, 52, "post_rst");
    release_out(1, "post_rst");

    // Simon128/256: 72 rounds, exercises z index wrap at 62
    send(3, {64'h74206e69206d6f6f, 64'h6d69732061207369},
         {64'h1f1e1d1c1b1a1918, 64'h1716151413121110, 64'h0f0e0d0c0b0a0908, 64'h0706050403020100},
         {64'h8d2b5579afc8a3a0, 64'h3bf72a87efe7b868});
    wait_out(3, 72, "s128");
    release_out(3, "s128");

    // Garbage presented while busy must be ignored
    send(1, PT96, KEY96, CT96);
    for (int i = 0; i < 10; i++) begin
      iv[1] = (i % 2 == 0);
      pt_b  = {$urandom, $urandom, $urandom, $urandom};
      key_b = {8{$urandom}};
      @(posedge clk); #1;
    end
    iv[1] = 1'b0;
    wait_out(1, 52, "ignore");
    release_out(1, "ignore");
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (ov[1]) seen++;
    end
    check("no_second_result", 128'(seen), 128'(0));
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
